// File: rtl/pe_out_writeback_if.sv
// Result/write bus between the PE output stage, the writeback block and the output buffer memory.
// The master side drives tile configuration, PE results and memory ready; the slave side drives writes and status.
interface pe_out_writeback_if #(
    parameter int DATA_WID = 16,
    parameter int ADDR_B   = 10
);
    logic                start;
    logic [ADDR_B-1:0]   base_addr;
    logic [ADDR_B-1:0]   tile_len;
    logic                relu_en;
    logic                in_valid;
    logic [DATA_WID-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_WID-1:0] out_data;
    logic [ADDR_B-1:0]   out_addr;
    logic                busy;
    logic                tile_done;
    logic                ovf;

    modport master (
        output start, base_addr, tile_len, relu_en, in_valid, in_data, out_ready,
        input  out_valid, out_data, out_addr, busy, tile_done, ovf
    );

    modport slave (
        input  start, base_addr, tile_len, relu_en, in_valid, in_data, out_ready,
        output out_valid, out_data, out_addr, busy, tile_done, ovf
    );
endinterface

// File: rtl/pe_out_writeback.sv
// Generic synchronous FIFO with a combinational head; push is allowed when full if a pop happens in the same cycle.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: none internally; the caller must gate push on full (unless popping) and pop on empty.
module pe_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
endmodule

// Writes one tile of PE results (optional ReLU) to consecutive output-buffer addresses through a small FIFO.
// Latency: a result accepted at edge t requests its write in the cycle after edge t.
// Backpressure: out_ready=0 holds the write; results arriving with no room, out of tile or past tile_len are dropped and flag ovf.
module pe_out_writeback #(
    parameter int DATA_WID   = 16,
    parameter int ADDR_B     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    pe_out_writeback_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    logic [ADDR_B-1:0]   base_q;
    logic [ADDR_B-1:0]   len_q;
    logic [ADDR_B-1:0]   acc_cnt;
    logic [ADDR_B-1:0]   wr_cnt;
    logic                relu_q;
    logic                busy_q;
    logic                done_q;
    logic                ovf_q;

    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic [DATA_WID-1:0] push_dat;
    logic [DATA_WID-1:0] head_dat;

    assign pop  = !fifo_empty && bus.out_ready;
    // A full FIFO still takes a result when the head leaves on the same edge.
    assign push = bus.in_valid && (state == RUN) && (acc_cnt != len_q) && (!fifo_full || pop);
    assign push_dat = (relu_q && bus.in_data[DATA_WID-1]) ? '0 : bus.in_data;

    pe_out_fifo #(
        .WIDTH (DATA_WID),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            relu_q  <= 1'b0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (bus.in_valid && !push) begin
                ovf_q <= 1'b1;
            end
            if (push) begin
                acc_cnt <= acc_cnt + ADDR_B'(1);
            end
            if (pop) begin
                wr_cnt <= wr_cnt + ADDR_B'(1);
            end
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        base_q  <= bus.base_addr;
                        len_q   <= bus.tile_len;
                        relu_q  <= bus.relu_en;
                        acc_cnt <= '0;
                        wr_cnt  <= '0;
                        if (bus.tile_len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Leave on the edge that completes the last write so tile_done follows it directly.
                    if (pop && (wr_cnt + ADDR_B'(1) == len_q)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : head_dat;
    assign bus.out_addr  = base_q + wr_cnt;
    assign bus.busy      = busy_q;
    assign bus.tile_done = done_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pe_out_writeback.sv
// Self-checking bench for pe_out_writeback: directed tiles plus random tiles against a queue-based reference model.
module tb_pe_out_writeback;
    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_out_writeback_if #(.DATA_WID(DW), .ADDR_B(AW)) bus ();

    pe_out_writeback #(
        .DATA_WID   (DW),
        .ADDR_B     (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    string cur_tag = "init";

    // Reference model: the words waiting to be written, in order, plus tile bookkeeping.
    logic [DW-1:0] m_q[$];
    bit m_run, m_done, m_ovf, m_relu;
    int m_acc, m_wr, m_len, m_base;

    logic [AW-1:0] w_addr[$];
    logic [DW-1:0] w_data[$];
    logic [AW-1:0] e_addr[$];
    logic [DW-1:0] e_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_run = 0; m_done = 0; m_ovf = 0; m_relu = 0;
        m_acc = 0; m_wr = 0; m_len = 0; m_base = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".out_data"},  32'(bus.out_data),  32'd0);
        check({tag, ".out_addr"},  32'(bus.out_addr),  32'd0);
        check({tag, ".busy"},      32'(bus.busy),      32'd0);
        check({tag, ".tile_done"}, 32'(bus.tile_done), 32'd0);
        check({tag, ".ovf"},       32'(bus.ovf),       32'd0);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_q.size() > 0));
        check({tag, ".busy"},      32'(bus.busy),      32'(m_run));
        check({tag, ".tile_done"}, 32'(bus.tile_done), 32'(m_done));
        check({tag, ".ovf"},       32'(bus.ovf),       32'(m_ovf));
        if (m_q.size() > 0) begin
            check({tag, ".out_data"}, 32'(bus.out_data), 32'(m_q[0]));
            check({tag, ".out_addr"}, 32'(bus.out_addr), 32'((m_base + m_wr) % (1 << AW)));
        end
    endtask

    task automatic cfg(input int base, input int len, input bit relu);
        bus.base_addr = AW'(base);
        bus.tile_len  = AW'(len);
        bus.relu_en   = relu;
    endtask

    // One clock cycle: called and returning at a falling edge.
    task automatic step(input bit st, input bit iv, input logic [DW-1:0] d, input bit rdy);
        bit pop, push, was_run, was_done;
        check_outputs(cur_tag);
        bus.start = st; bus.in_valid = iv; bus.in_data = d; bus.out_ready = rdy;
        if (bus.out_valid && rdy) begin
            w_addr.push_back(bus.out_addr);
            w_data.push_back(bus.out_data);
        end
        was_run  = m_run;
        was_done = m_done;
        pop  = (m_q.size() > 0) && rdy;
        push = was_run && iv && (m_acc < m_len) && ((m_q.size() < DEPTH) || pop);
        if (iv && !push) m_ovf = 1;
        if (pop) begin
            void'(m_q.pop_front());
            m_wr++;
        end
        if (push) begin
            m_q.push_back((m_relu && d[DW-1]) ? DW'(0) : d);
            m_acc++;
        end
        m_done = 0;
        if (was_run && pop && m_wr == m_len) begin
            m_run  = 0;
            m_done = 1;
        end
        if (!was_run && !was_done && st) begin
            m_base = int'(bus.base_addr); m_len = int'(bus.tile_len); m_relu = bus.relu_en;
            m_acc = 0; m_wr = 0;
            if (m_len == 0) m_done = 1;
            else m_run = 1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.start = 0;
        bus.in_valid = 0;
    endtask

    task automatic clear_log();
        w_addr.delete(); w_data.delete(); e_addr.delete(); e_data.delete();
    endtask

    task automatic check_log(input string tag);
        check({tag, ".nwrites"}, 32'(w_addr.size()), 32'(e_addr.size()));
        for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), 32'(w_addr[i]), 32'(e_addr[i]));
            check($sformatf("%s.data%0d", tag, i), 32'(w_data[i]), 32'(e_data[i]));
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 1);
    endtask

    initial begin
        logic [DW-1:0] rd [4];
        int guard;
        bus.start = 0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        cfg(0, 0, 0);
        model_reset();
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        cur_tag = "idle";
        drain(2);

        // Basic tile, with a start mid-tile that must be ignored.
        cur_tag = "basic"; clear_log();
        cfg(100, 3, 0);
        step(1, 0, '0, 1);
        step(0, 1, 16'd5, 1);
        cfg(500, 1, 1);
        step(1, 1, 16'hFFFE, 1);
        step(0, 1, 16'd7, 1);
        drain(3);
        e_addr = '{10'd100, 10'd101, 10'd102};
        e_data = '{16'd5, 16'hFFFE, 16'd7};
        check_log("basic");

        cur_tag = "relu"; clear_log();
        cfg(200, 3, 1);
        step(1, 0, '0, 1);
        step(0, 1, 16'h8000, 1);
        step(0, 1, 16'h0000, 1);
        step(0, 1, 16'h0001, 1);
        drain(3);
        e_addr = '{10'd200, 10'd201, 10'd202};
        e_data = '{16'd0, 16'd0, 16'd1};
        check_log("relu");

        // Full FIFO, fifth result arrives on the cycle the head is written.
        cur_tag = "pushpop"; clear_log();
        cfg(300, 5, 0);
        step(1, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, DW'(11 + i), 0);
        step(0, 1, 16'd15, 1);
        drain(6);
        check("pushpop.ovf_final", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < 5; i++) begin
            e_addr.push_back(AW'(300 + i));
            e_data.push_back(DW'(11 + i));
        end
        check_log("pushpop");

        cur_tag = "wrap"; clear_log();
        cfg(1022, 4, 0);
        step(1, 0, '0, 1);
        for (int i = 0; i < 4; i++) begin
            rd[i] = DW'($urandom);
            step(0, 1, rd[i], 1);
        end
        drain(3);
        e_addr = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        for (int i = 0; i < 4; i++) e_data.push_back(rd[i]);
        check_log("wrap");

        cur_tag = "len0"; clear_log();
        cfg(50, 0, 0);
        step(1, 0, '0, 1);
        check("len0.tile_done", 32'(bus.tile_done), 32'd1);
        check("len0.out_valid", 32'(bus.out_valid), 32'd0);
        step(0, 0, '0, 1);
        check("len0.tile_done_drop", 32'(bus.tile_done), 32'd0);
        drain(1);
        check_log("len0");

        // Backpressure: fifth result finds the FIFO full with tile room left.
        cur_tag = "bp"; clear_log();
        cfg(400, 8, 0);
        step(1, 0, '0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, DW'(21 + i), 0);
        check("bp.ovf", 32'(bus.ovf), 32'd1);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, DW'(26 + i), 1);
        drain(6);
        for (int i = 0; i < 8; i++) begin
            e_addr.push_back(AW'(400 + i));
            e_data.push_back(DW'(i < 4 ? 21 + i : 22 + i));
        end
        check_log("bp");

        cur_tag = "rand";
        for (int t = 0; t < 3; t++) begin
            cfg(int'($urandom_range(0, 1023)), int'($urandom_range(1, 12)), bit'($urandom_range(0, 1)));
            step(1, 0, '0, 1);
            guard = 0;
            while ((m_run || m_done) && guard < 400) begin
                step(0, ($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0);
                guard++;
            end
            check("rand.finished_in_budget", 32'(guard < 400), 32'd1);
        end
        drain(2);

        // Asynchronous reset in the middle of a tile.
        cur_tag = "midrst"; clear_log();
        cfg(600, 6, 0);
        step(1, 0, '0, 0);
        step(0, 1, 16'd41, 0);
        step(0, 1, 16'd42, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst.async");
        model_reset();
        @(negedge clk);
        check_zero("midrst.held");
        rst_n = 1'b1;
        step(0, 0, '0, 1);
        cur_tag = "clean"; clear_log();
        cfg(700, 2, 0);
        step(1, 0, '0, 1);
        step(0, 1, 16'd31, 1);
        step(0, 1, 16'd32, 1);
        drain(3);
        e_addr = '{10'd700, 10'd701};
        e_data = '{16'd31, 16'd32};
        check_log("clean");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
